// File: rtl/dist_pkg.sv
// Shared definitions for the distance scan path: channel count, word width, error code and
// scan FSM state encoding.
package dist_pkg;

   localparam int unsigned N_CH   = 6;
   localparam int unsigned DATA_W = 13;
   localparam int unsigned CH_W   = 3;

   localparam logic [DATA_W-1:0] ERR_VAL = 13'h1FFF;
   localparam logic [CH_W-1:0]   LastCh  = CH_W'(N_CH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSettle,
      StTrig,
      StWait,
      StWrite
   } scan_state_e;

endpackage

// File: rtl/cycle_counter.sv
// Up-counter with synchronous clear that saturates at a runtime limit and flags when the
// limit has been reached.
module cycle_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] limit_i,
   output logic             tc_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != limit_i)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/dist_scan_ctrl.sv
// Scans the distance channels in turn: settle, trigger the shared measurement unit, wait for
// the result or a timeout, and write the value into the distance RAM at addr = channel.
module dist_scan_ctrl
   import dist_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned SETTLE_CYC  = 1000
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   input  logic              meas_done,
   input  logic [DATA_W-1:0] meas_value,
   output logic              meas_start,
   output logic [CH_W-1:0]   meas_sel,
   output logic              ram_we,
   output logic [CH_W-1:0]   ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              busy,
   output logic              scan_done,
   output logic [N_CH-1:0]   timeout_flags
);

   localparam int unsigned CntMax = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int unsigned CntW   = $clog2(CntMax);
   localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

   scan_state_e       state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [N_CH-1:0]   flags_q, flags_d;
   logic              busy_q, meas_start_q, ram_we_q, scan_done_q;

   logic              cnt_clr, cnt_tc;
   logic [CntW-1:0]   cnt_limit;

   // One counter serves SETTLE and WAIT; it is held cleared elsewhere so it restarts at entry.
   assign cnt_clr   = clear || !((state_q == StSettle) || (state_q == StWait));
   assign cnt_limit = (state_q == StWait) ? TimeoutLast : SettleLast;

   cycle_counter #(
      .Width (CntW)
   ) u_cycle_counter (
      .clk_i   (clk),
      .clr_i   (cnt_clr),
      .en_i    (!cnt_clr),
      .limit_i (cnt_limit),
      .tc_o    (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = data_q;
      flags_d = flags_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSettle;
               ch_d    = '0;
               flags_d = '0;
            end
         end
         StSettle: begin
            if (abort) state_d = StIdle;
            else if (cnt_tc) state_d = StTrig;
         end
         StTrig: begin
            state_d = abort ? StIdle : StWait;
         end
         StWait: begin
            // A result arriving on the timeout cycle still counts as a good measurement.
            if (abort) begin
               state_d = StIdle;
            end else if (meas_done) begin
               data_d  = meas_value;
               state_d = StWrite;
            end else if (cnt_tc) begin
               data_d        = ERR_VAL;
               flags_d[ch_q] = 1'b1;
               state_d       = StWrite;
            end
         end
         StWrite: begin
            if (ch_q != LastCh) begin
               if (abort) begin
                  state_d = StIdle;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = StSettle;
               end
            end else if (continuous && !abort) begin
               ch_d    = '0;
               flags_d = '0;
               state_d = StSettle;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= StIdle;
         ch_q         <= '0;
         data_q       <= '0;
         flags_q      <= '0;
         busy_q       <= 1'b0;
         meas_start_q <= 1'b0;
         ram_we_q     <= 1'b0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         data_q       <= data_d;
         flags_q      <= flags_d;
         busy_q       <= (state_d != StIdle);
         meas_start_q <= (state_d == StTrig);
         ram_we_q     <= (state_d == StWrite);
         scan_done_q  <= (state_d == StWrite) && (ch_d == LastCh);
      end
   end

   assign meas_start    = meas_start_q;
   assign meas_sel      = ch_q;
   assign ram_we        = ram_we_q;
   assign ram_addr      = ch_q;
   assign ram_data      = data_q;
   assign busy          = busy_q;
   assign scan_done     = scan_done_q;
   assign timeout_flags = flags_q;

endmodule

// File: tb/tb_dist_scan_ctrl.sv
// Directed bench for dist_scan_ctrl with a delay-programmable measurement model and a RAM
// shadow built from the write port.
module tb_dist_scan_ctrl;
   import dist_pkg::*;

   localparam int unsigned Settle  = 4;
   localparam int unsigned Timeout = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              clear, start, continuous, abort;
   logic              meas_done_m, spur_done, meas_done;
   logic [DATA_W-1:0] model_val, spur_val, meas_value;
   logic              meas_start, ram_we, busy, scan_done;
   logic [CH_W-1:0]   meas_sel, ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic [N_CH-1:0]   timeout_flags;

   assign meas_done  = meas_done_m | spur_done;
   assign meas_value = spur_done ? spur_val : model_val;

   dist_scan_ctrl #(
      .TIMEOUT_CYC (Timeout),
      .SETTLE_CYC  (Settle)
   ) dut (
      .clk           (clk),
      .clear         (clear),
      .start         (start),
      .continuous    (continuous),
      .abort         (abort),
      .meas_done     (meas_done),
      .meas_value    (meas_value),
      .meas_start    (meas_start),
      .meas_sel      (meas_sel),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_data      (ram_data),
      .busy          (busy),
      .scan_done     (scan_done),
      .timeout_flags (timeout_flags)
   );

   int unsigned       model_k [N_CH];
   int                total = 0;
   int                passed = 0;
   int                starts_cnt = 0;
   int                wr_cnt = 0;
   int                sd_cnt = 0;
   logic [DATA_W-1:0] shadow [N_CH];
   logic              addr_bad = 1'b0;
   logic [CH_W-1:0]   prev_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Measurement unit: done k cycles after the trigger (k = 0 means never answer).
   initial begin : model
      int unsigned     k;
      logic [CH_W-1:0] c;
      meas_done_m = 1'b0;
      model_val   = '0;
      forever begin
         @(negedge clk);
         if (meas_start === 1'b1) begin
            c = meas_sel;
            k = model_k[c];
            if (k != 0) begin
               repeat (k) @(negedge clk);
               meas_done_m = 1'b1;
               model_val   = DATA_W'(100 + int'(c));
               @(negedge clk);
               meas_done_m = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      for (int i = 0; i < N_CH; i++) shadow[i] = '0;
      forever begin
         @(negedge clk);
         if (meas_start === 1'b1) starts_cnt++;
         if (ram_we === 1'b1) begin
            wr_cnt++;
            shadow[ram_addr] = ram_data;
            if (ram_addr !== prev_addr) addr_bad = 1'b1;
         end
         if (scan_done === 1'b1) sd_cnt++;
         prev_addr = ram_addr;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic run_scan(output int n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_meas_start"}, 32'(meas_start), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
      chk({tag, "_flags"}, 32'(timeout_flags), 32'd0);
      chk({tag, "_meas_sel"}, 32'(meas_sel), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_data"}, 32'(ram_data), 32'd0);
   endtask

   initial begin : main
      int n, s0, w0, d0;
      clear = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
      spur_done = 1'b0; spur_val = '0;
      for (int i = 0; i < N_CH; i++) model_k[i] = 3;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      clear = 1'b0;
      @(negedge clk);

      // Plain single scan: 6 channels x (4 + 1 + 3 + 1) cycles.
      s0 = starts_cnt; w0 = wr_cnt; d0 = sd_cnt;
      run_scan(n);
      @(negedge clk);
      chk("t1_cycles", 32'(n), 32'd54);
      chk("t1_starts", 32'(starts_cnt - s0), 32'd6);
      chk("t1_writes", 32'(wr_cnt - w0), 32'd6);
      chk("t1_scan_done", 32'(sd_cnt - d0), 32'd1);
      chk("t1_flags", 32'(timeout_flags), 32'd0);
      for (int i = 0; i < N_CH; i++) chk("t1_ram", 32'(shadow[i]), 32'(100 + i));

      // Channel 2 never answers: error code, flag bit 2, 20 cycles in WAIT.
      model_k[2] = 0;
      run_scan(n);
      @(negedge clk);
      chk("t2_cycles", 32'(n), 32'd71);
      chk("t2_ram2", 32'(shadow[2]), 32'h1FFF);
      chk("t2_flags", 32'(timeout_flags), 32'b000100);
      chk("t2_ram1", 32'(shadow[1]), 32'd101);
      chk("t2_ram3", 32'(shadow[3]), 32'd103);
      model_k[2] = 3;

      // Channel 4 answers on the very timeout cycle: the result wins.
      model_k[4] = Timeout;
      run_scan(n);
      @(negedge clk);
      chk("t3_cycles", 32'(n), 32'd71);
      chk("t3_ram4", 32'(shadow[4]), 32'd104);
      chk("t3_ram2", 32'(shadow[2]), 32'd102);
      chk("t3_flags", 32'(timeout_flags), 32'd0);
      model_k[4] = 3;

      // Continuous restart clears flags; then abort during WAIT of channel 3.
      continuous = 1'b1;
      model_k[1] = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!scan_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_reach_done", 32'(n < 200), 32'd1);
      chk("t4_flags_before", 32'(timeout_flags), 32'b000010);
      @(negedge clk);
      chk("t4_restart_busy", 32'(busy), 32'd1);
      chk("t4_restart_sel", 32'(meas_sel), 32'd0);
      chk("t4_restart_flags", 32'(timeout_flags), 32'd0);
      chk("t4_restart_we", 32'(ram_we), 32'd0);
      model_k[1] = 3;
      n = 0;
      while (!(meas_start && meas_sel == 3'd3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_reach_trig3", 32'(n < 200), 32'd1);
      @(negedge clk);
      abort = 1'b1;
      w0 = wr_cnt; d0 = sd_cnt;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_abort_idle", 32'(busy), 32'd0);
      repeat (30) @(negedge clk);
      chk("t4_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("t4_no_scan_done", 32'(sd_cnt - d0), 32'd0);
      chk("t4_stay_idle", 32'(busy), 32'd0);

      // Abort in WRITE of the last channel: write and scan_done happen, no restart.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(ram_we && ram_addr == 3'd5) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_write5", 32'(n < 200), 32'd1);
      chk("t5_scan_done", 32'(scan_done), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_idle", 32'(busy), 32'd0);
      s0 = starts_cnt;
      repeat (20) @(negedge clk);
      chk("t5_no_restart", 32'(starts_cnt - s0), 32'd0);
      chk("t5_still_idle", 32'(busy), 32'd0);
      chk("t5_ram5", 32'(shadow[5]), 32'd105);
      continuous = 1'b0;

      // Stray done and start while busy are ignored; clear in WAIT resets everything.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(ram_we && ram_addr == 3'd0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t6_write0_data", 32'(ram_data), 32'd100);
      @(negedge clk);
      start = 1'b1;
      spur_done = 1'b1;
      spur_val = 13'd777;
      @(negedge clk);
      start = 1'b0;
      spur_done = 1'b0;
      n = 0;
      while (!meas_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t6_sel_after_start", 32'(meas_sel), 32'd1);
      chk("t6_data_held", 32'(ram_data), 32'd100);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      chk_all_zero("t6_clear");
      clear = 1'b0;
      repeat (30) @(negedge clk);
      chk("t6_idle_after", 32'(busy), 32'd0);
      chk("t6_ram0", 32'(shadow[0]), 32'd100);
      chk("t6_addr_stable", 32'(addr_bad), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
